// File: rtl/calc_seq_pkg.sv
// Shared state encoding, function codes and control bundle for calc_sequencer.
package calc_seq_pkg;

  localparam int unsigned FUNCT_W = 3;
  localparam int unsigned IMM_W   = 14;

  localparam logic [FUNCT_W-1:0] FN_ADD  = FUNCT_W'(0);
  localparam logic [FUNCT_W-1:0] FN_SUB  = FUNCT_W'(1);
  localparam logic [FUNCT_W-1:0] FN_ADDP = FUNCT_W'(2);
  localparam logic [FUNCT_W-1:0] FN_SUBP = FUNCT_W'(3);
  localparam logic [FUNCT_W-1:0] FN_MUL  = FUNCT_W'(4);
  localparam logic [FUNCT_W-1:0] FN_CLR  = FUNCT_W'(5);
  localparam logic [FUNCT_W-1:0] FN_NOP  = FUNCT_W'(6);
  localparam logic [FUNCT_W-1:0] FN_HALT = FUNCT_W'(7);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MUL_INIT,
    MUL_LOOP,
    MUL_DONE,
    HALT
  } state_t;

  // Datapath control bundle, registered as one word
  typedef struct packed {
    logic pc_en;
    logic sign_ctrl;
    logic store_prev_ctrl;
    logic accum_wr_en;
    logic accum_clr;
    logic busy;
    logic retired;
    logic halted;
  } ctrl_t;

endpackage

// File: rtl/calc_seq_counter.sv
// Loadable saturating down-counter with zero/one flags; shared by fetch timeout and MUL iterations.
module calc_seq_counter #(
  parameter int unsigned W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c,
  output logic         one_c
);

  logic [W-1:0] count;

  // Load wins over decrement; decrement stops at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);
  assign one_c  = (count == W'(1));

endmodule

// File: rtl/calc_sequencer.sv
// Fetch/decode/execute controller for the calculator datapath with iterative MUL and HALT.
// Build macro CALC_SEQ_OVF_TRAP_EN adds alu_ovf: an overflowing accumulator write halts with err.
module calc_sequencer
  import calc_seq_pkg::*;
#(
  parameter int unsigned CNT_W         = 14,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               inst_valid,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [IMM_W-1:0]   imm_b,
`ifdef CALC_SEQ_OVF_TRAP_EN
  input  logic               alu_ovf,
`endif
  output logic               pc_en,
  output logic               sign_ctrl,
  output logic               store_prev_ctrl,
  output logic               accum_wr_en,
  output logic               accum_clr,
  output logic               busy,
  output logic               retired,
  output logic               halted,
  output logic               err
);

  state_t             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic               err_q, err_set;
  logic [FUNCT_W-1:0] funct_q;
  logic [IMM_W-1:0]   imm_q;
  logic               latch;
  logic               cnt_load, cnt_dec, cnt_zero, cnt_one;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               trap_c;

`ifdef CALC_SEQ_OVF_TRAP_EN
  assign trap_c = alu_ovf & ctrl_q.accum_wr_en;
`else
  assign trap_c = 1'b0;
`endif

  calc_seq_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero),
    .one_c    (cnt_one)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      err_q   <= 1'b0;
      funct_q <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_q | err_set;
      if (latch) begin
        funct_q <= funct;
        imm_q   <= imm_b;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ctrl_d       = '0;
    err_set      = 1'b0;
    latch        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = (state_q == FETCH) || (state_q == MUL_LOOP);

    unique case (state_q)
      IDLE:     if (start) state_d = FETCH;
      FETCH: begin
        if (inst_valid) begin
          latch   = 1'b1;
          state_d = DECODE;
        end else if (cnt_one) begin
          err_set = 1'b1;
          state_d = HALT;
        end
      end
      DECODE: begin
        case (funct_q)
          FN_MUL:  state_d = MUL_INIT;
          FN_HALT: state_d = HALT;
          default: state_d = EXEC;
        endcase
      end
      EXEC:     state_d = FETCH;
      MUL_INIT: state_d = cnt_zero ? MUL_DONE : MUL_LOOP;
      MUL_LOOP: if (cnt_one) state_d = MUL_DONE;
      MUL_DONE: state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = IDLE;
    endcase

    // An overflowing write abandons the instruction; the write itself still lands
    if (trap_c) begin
      err_set = 1'b1;
      state_d = HALT;
    end

    // Arm the fetch timeout on every entry to FETCH; arm the MUL count on MUL_INIT entry
    if ((state_d == FETCH) && (state_q != FETCH)) begin
      cnt_load     = 1'b1;
      cnt_load_val = CNT_W'(FETCH_TIMEOUT);
    end else if (state_d == MUL_INIT) begin
      cnt_load     = 1'b1;
      cnt_load_val = CNT_W'(imm_q);
    end

    ctrl_d.busy   = (state_d != IDLE) && (state_d != HALT);
    ctrl_d.halted = (state_d == HALT);
    case (state_d)
      EXEC: begin
        ctrl_d.accum_wr_en     = ~funct_q[2];
        ctrl_d.accum_clr       = (funct_q == FN_CLR);
        ctrl_d.sign_ctrl       = funct_q[0];
        ctrl_d.store_prev_ctrl = ~funct_q[1];
        ctrl_d.pc_en           = 1'b1;
        ctrl_d.retired         = 1'b1;
      end
      MUL_INIT: ctrl_d.accum_clr = 1'b1;
      MUL_LOOP: ctrl_d.accum_wr_en = 1'b1;
      MUL_DONE: begin
        ctrl_d.pc_en   = 1'b1;
        ctrl_d.retired = 1'b1;
      end
      default: ;
    endcase
  end

  // A trap in EXEC has to withdraw the same-cycle PC advance and retire pulse
  assign pc_en           = ctrl_q.pc_en & ~trap_c;
  assign retired         = ctrl_q.retired & ~trap_c;
  assign sign_ctrl       = ctrl_q.sign_ctrl;
  assign store_prev_ctrl = ctrl_q.store_prev_ctrl;
  assign accum_wr_en     = ctrl_q.accum_wr_en;
  assign accum_clr       = ctrl_q.accum_clr;
  assign busy            = ctrl_q.busy;
  assign halted          = ctrl_q.halted;
  assign err             = err_q;

endmodule
